// File: rtl/alu_mdu.sv
// ALU plus iterative multiply/divide unit with a valid/ready handshake on both sides.
// Define ALU_MDU_DIV_EN to build the divider; without it the divide opcodes report illegal.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no result pending, ready for a request
// MUL     | shift-add multiply, one multiplier bit per cycle
// DIV     | restoring divide on magnitudes (ALU_MDU_DIV_EN builds only)
// DONE    | result valid, held until out_ready
module alu_mdu #(
    parameter int WIDTH  = 32,
    parameter int ALUC_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ALUC_W-1:0] aluc,
    input  logic [WIDTH-1:0]  num1,
    input  logic [WIDTH-1:0]  num2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              illegal
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [ALUC_W-1:0] OP_ADD      = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] OP_SUB      = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] OP_SLL      = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] OP_XOR      = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] OP_SRL      = ALUC_W'(4);
    localparam logic [ALUC_W-1:0] OP_SRA      = ALUC_W'(5);
    localparam logic [ALUC_W-1:0] OP_OR       = ALUC_W'(6);
    localparam logic [ALUC_W-1:0] OP_AND      = ALUC_W'(7);
    localparam logic [ALUC_W-1:0] OP_EQ       = ALUC_W'(8);
    localparam logic [ALUC_W-1:0] OP_NE       = ALUC_W'(9);
    localparam logic [ALUC_W-1:0] OP_LT       = ALUC_W'(10);
    localparam logic [ALUC_W-1:0] OP_GE       = ALUC_W'(11);
    localparam logic [ALUC_W-1:0] OP_LTU      = ALUC_W'(12);
    localparam logic [ALUC_W-1:0] OP_GEU      = ALUC_W'(13);
    localparam logic [ALUC_W-1:0] OP_ADD_LUI  = ALUC_W'(14);
    localparam logic [ALUC_W-1:0] OP_ADD_JALR = ALUC_W'(15);
    localparam logic [ALUC_W-1:0] OP_MUL      = ALUC_W'(16);
    localparam logic [ALUC_W-1:0] OP_MULH     = ALUC_W'(17);
    localparam logic [ALUC_W-1:0] OP_MULHSU   = ALUC_W'(18);
    localparam logic [ALUC_W-1:0] OP_MULHU    = ALUC_W'(19);
`ifdef ALU_MDU_DIV_EN
    localparam logic [ALUC_W-1:0] OP_DIV      = ALUC_W'(20);
    localparam logic [ALUC_W-1:0] OP_DIVU     = ALUC_W'(21);
    localparam logic [ALUC_W-1:0] OP_REM      = ALUC_W'(22);
    localparam logic [ALUC_W-1:0] OP_REMU     = ALUC_W'(23);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef ALU_MDU_DIV_EN
        ST_DIV  = 2'd3,
`endif
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opd;
    logic               r_neg;
    logic               r_hi_sel;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_illegal;

    logic               w_accept;
    logic [SH_W-1:0]    w_shamt;
    logic               w_sa_op;
    logic               w_sb_op;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH-1:0]   w_imm_res;
    logic               w_imm_ill;
    logic               w_go_mul;
    logic               w_go_div;
    logic [WIDTH-1:0]   w_sum;

    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [2*WIDTH-1:0] w_mul_fix;
    logic [WIDTH-1:0]   w_mul_res;

    assign in_ready  = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign illegal   = r_illegal;

    assign w_shamt = num2[SH_W-1:0];
    assign w_sum   = num1 + num2;

    always_comb begin
        w_sa_op = (aluc == OP_MULH) || (aluc == OP_MULHSU);
        w_sb_op = (aluc == OP_MULH);
`ifdef ALU_MDU_DIV_EN
        if ((aluc == OP_DIV) || (aluc == OP_REM)) begin
            w_sa_op = 1'b1;
            w_sb_op = 1'b1;
        end
`endif
    end

    assign w_sa   = w_sa_op && num1[WIDTH-1];
    assign w_sb   = w_sb_op && num2[WIDTH-1];
    assign w_mag1 = w_sa ? -num1 : num1;
    assign w_mag2 = w_sb ? -num2 : num2;

`ifdef ALU_MDU_DIV_EN
    logic               r_rem_sel;
    logic               r_rem_neg;
    logic               w_ovf;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_fit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_div_res;

    assign w_ovf      = (num1 == {1'b1, {(WIDTH-1){1'b0}}}) && (num2 == {WIDTH{1'b1}});
    assign w_trial    = {r_hi, r_lo[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_opd};
    assign w_fit      = ~w_diff[WIDTH];
    assign w_rem_next = w_fit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_next = {r_lo[WIDTH-2:0], w_fit};
    assign w_div_res  = r_rem_sel ? (r_rem_neg ? -w_rem_next : w_rem_next)
                                  : (r_neg ? -w_quo_next : w_quo_next);
`endif

    // One multiplier bit per cycle: add into the high half, shift the whole product right.
    assign w_madd     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : {(WIDTH+1){1'b0}});
    assign w_mul_prod = {w_madd, r_lo[WIDTH-1:1]};
    assign w_mul_fix  = r_neg ? -w_mul_prod : w_mul_prod;
    assign w_mul_res  = r_hi_sel ? w_mul_fix[2*WIDTH-1:WIDTH] : w_mul_fix[WIDTH-1:0];

    always_comb begin
        w_imm_res = '0;
        w_imm_ill = 1'b0;
        w_go_mul  = 1'b0;
        w_go_div  = 1'b0;
        case (aluc)
            OP_ADD:      w_imm_res = w_sum;
            OP_SUB:      w_imm_res = num1 - num2;
            OP_SLL:      w_imm_res = num1 << w_shamt;
            OP_XOR:      w_imm_res = num1 ^ num2;
            OP_SRL:      w_imm_res = num1 >> w_shamt;
            OP_SRA:      w_imm_res = $signed(num1) >>> w_shamt;
            OP_OR:       w_imm_res = num1 | num2;
            OP_AND:      w_imm_res = num1 & num2;
            OP_EQ:       w_imm_res = {{(WIDTH-1){1'b0}}, (num1 == num2)};
            OP_NE:       w_imm_res = {{(WIDTH-1){1'b0}}, (num1 != num2)};
            OP_LT:       w_imm_res = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
            OP_GE:       w_imm_res = {{(WIDTH-1){1'b0}}, ($signed(num1) >= $signed(num2))};
            OP_LTU:      w_imm_res = {{(WIDTH-1){1'b0}}, (num1 < num2)};
            OP_GEU:      w_imm_res = {{(WIDTH-1){1'b0}}, (num1 >= num2)};
            OP_ADD_LUI:  w_imm_res = num2;
            OP_ADD_JALR: w_imm_res = {w_sum[WIDTH-1:1], 1'b0};
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: w_go_mul = 1'b1;
`ifdef ALU_MDU_DIV_EN
            // Zero divisor and signed overflow bypass the iteration entirely.
            OP_DIV, OP_REM: begin
                if (num2 == '0)
                    w_imm_res = (aluc == OP_DIV) ? {WIDTH{1'b1}} : num1;
                else if (w_ovf)
                    w_imm_res = (aluc == OP_DIV) ? num1 : '0;
                else
                    w_go_div = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
                if (num2 == '0)
                    w_imm_res = (aluc == OP_DIVU) ? {WIDTH{1'b1}} : num1;
                else
                    w_go_div = 1'b1;
            end
`endif
            default:     w_imm_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opd       <= '0;
            r_neg       <= 1'b0;
            r_hi_sel    <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            r_rem_sel   <= 1'b0;
            r_rem_neg   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if ((r_state == ST_DONE) && out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        r_hi  <= '0;
                        r_neg <= w_sa ^ w_sb;
                        r_cnt <= CNT_W'(WIDTH-1);
                        if (w_go_mul) begin
                            r_state     <= ST_MUL;
                            r_out_valid <= 1'b0;
                            r_lo        <= w_mag2;
                            r_opd       <= w_mag1;
                            r_hi_sel    <= (aluc != OP_MUL);
                        end
`ifdef ALU_MDU_DIV_EN
                        else if (w_go_div) begin
                            r_state     <= ST_DIV;
                            r_out_valid <= 1'b0;
                            r_lo        <= w_mag1;
                            r_opd       <= w_mag2;
                            r_rem_sel   <= (aluc == OP_REM) || (aluc == OP_REMU);
                            r_rem_neg   <= w_sa;
                        end
`endif
                        else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_imm_res;
                            r_illegal   <= w_imm_ill;
                        end
                    end
                end
                ST_MUL: begin
                    r_hi <= w_mul_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_mul_prod[WIDTH-1:0];
                    if (r_cnt == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_mul_res;
                        r_illegal   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef ALU_MDU_DIV_EN
                ST_DIV: begin
                    r_hi <= w_rem_next;
                    r_lo <= w_quo_next;
                    if (r_cnt == '0) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_div_res;
                        r_illegal   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: vector table with latency checks, a result scoreboard,
// and hand sequences for output stall, back-to-back accept and reset during a multiply.
module tb_alu_mdu;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_XOR = 5'd3;
    localparam logic [4:0] OP_SRL = 5'd4,  OP_SRA = 5'd5,  OP_OR  = 5'd6,  OP_AND = 5'd7;
    localparam logic [4:0] OP_EQ  = 5'd8,  OP_NE  = 5'd9,  OP_LT  = 5'd10, OP_GE  = 5'd11;
    localparam logic [4:0] OP_LTU = 5'd12, OP_GEU = 5'd13, OP_LUI = 5'd14, OP_JALR = 5'd15;
    localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
    localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  aluc;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    alu_mdu #(.WIDTH(32), .ALUC_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluc      (aluc),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output actual=%0h required=none", result);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", 64'(result), 64'(mon_e.res));
                chk("sb_illegal", 64'(illegal), 64'(mon_e.ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ei, input bit push, output int waits);
        bit acc;
        acc   = 1'b0;
        waits = 0;
        aluc = op; num1 = a; num2 = b; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            waits++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
        end
        @(posedge clk);
        if (push) sb.push_back('{er, ei});
        #1;
        in_valid = 1'b0;
    endtask

    // Counts falling edges after acceptance until out_valid; optionally drives junk requests meanwhile.
    task automatic wait_out(input bit garble, output int lat, output bit rdy_low);
        lat     = 0;
        rdy_low = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (in_ready) rdy_low = 1'b0;
            if (garble && lat < 20) begin
                in_valid = 1'b1;
                aluc     = 5'($urandom_range(0, 31));
                num1     = $urandom;
                num2     = $urandom;
            end else begin
                in_valid = 1'b0;
            end
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_valid_timeout actual=0 required=1");
        end
    endtask

    initial begin
        int   waits;
        int   lat;
        bit   rdy_low;
        bit   stable;
        bit   seen;

        vecs.push_back('{OP_ADD,    32'd5,          32'd7,          32'd12,         1'b0, 1});
        vecs.push_back('{OP_SUB,    32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0, 1});
        vecs.push_back('{OP_SLL,    32'd1,          32'd33,         32'd2,          1'b0, 1});
        vecs.push_back('{OP_XOR,    32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_FF00,  1'b0, 1});
        vecs.push_back('{OP_SRL,    32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1});
        vecs.push_back('{OP_SRA,    32'h8000_0000,  32'd36,         32'hF800_0000,  1'b0, 1});
        vecs.push_back('{OP_OR,     32'h0000_0F00,  32'h0000_00F0,  32'h0000_0FF0,  1'b0, 1});
        vecs.push_back('{OP_AND,    32'h0000_FF00,  32'h0000_0FF0,  32'h0000_0F00,  1'b0, 1});
        vecs.push_back('{OP_EQ,     32'd3,          32'd3,          32'd1,          1'b0, 1});
        vecs.push_back('{OP_NE,     32'd3,          32'd3,          32'd0,          1'b0, 1});
        vecs.push_back('{OP_LT,     32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1});
        vecs.push_back('{OP_GE,     32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1});
        vecs.push_back('{OP_LTU,    32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1});
        vecs.push_back('{OP_GEU,    32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1});
        vecs.push_back('{OP_LUI,    32'd123,        32'h1234_5000,  32'h1234_5000,  1'b0, 1});
        vecs.push_back('{OP_JALR,   32'h0000_1001,  32'd2,          32'h0000_1002,  1'b0, 1});
        vecs.push_back('{OP_MUL,    32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB,  1'b0, 33});
        vecs.push_back('{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b0, 33});
        vecs.push_back('{OP_MULH,   32'h8000_0000,  32'd2,          32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 33});
        vecs.push_back('{OP_MULHU,  32'h0001_0000,  32'h0001_0000,  32'd1,          1'b0, 33});
        vecs.push_back('{5'd31,     32'd9,          32'd9,          32'd0,          1'b1, 1});
`ifdef ALU_MDU_DIV_EN
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, 33});
        vecs.push_back('{OP_DIV,    32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 33});
        vecs.push_back('{OP_REM,    32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, 33});
        vecs.push_back('{OP_DIVU,   32'd100,        32'd7,          32'd14,         1'b0, 33});
        vecs.push_back('{OP_REMU,   32'd100,        32'd7,          32'd2,          1'b0, 33});
        vecs.push_back('{OP_DIVU,   32'd100,        32'd0,          32'hFFFF_FFFF,  1'b0, 1});
        vecs.push_back('{OP_REMU,   32'd100,        32'd0,          32'd100,        1'b0, 1});
        vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1});
        vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1});
`else
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'd0,          1'b1, 1});
        vecs.push_back('{OP_DIVU,   32'd100,        32'd0,          32'd0,          1'b1, 1});
        vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, 1});
        vecs.push_back('{OP_REMU,   32'd100,        32'd7,          32'd0,          1'b1, 1});
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluc = '0; num1 = '0; num2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_illegal",   64'(illegal),   64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill, 1'b1, waits);
            wait_out(vecs[i].lat > 1, lat, rdy_low);
            chk($sformatf("latency_%0d", i), 64'(lat), 64'(vecs[i].lat));
            if (vecs[i].lat > 1) chk($sformatf("busy_in_ready_low_%0d", i), 64'(rdy_low), 64'd1);
            step();
        end

        // Output stall followed by a same-cycle accept of the next request.
        out_ready = 1'b0;
        issue(OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1, waits);
        wait_out(1'b0, lat, rdy_low);
        chk("stall_latency", 64'(lat), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || result !== 32'd12 || illegal !== 1'b0) stable = 1'b0;
        end
        chk("stall_stable", 64'(stable), 64'd1);
        chk("stall_result", 64'(result), 64'd12);
        step();
        out_ready = 1'b1;
        issue(OP_SLL, 32'd1, 32'd33, 32'd2, 1'b0, 1'b1, waits);
        chk("b2b_accept_waits", 64'(waits), 64'd0);
        wait_out(1'b0, lat, rdy_low);
        chk("b2b_latency", 64'(lat), 64'd1);
        step();

        // Reset ten cycles into a multiply: no result may appear afterwards.
        issue(OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, waits);
        repeat (10) step();
        rst = 1'b1;
        @(negedge clk);
        chk("mulrst_in_ready_during_rst", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mulrst_out_valid", 64'(out_valid), 64'd0);
        chk("mulrst_in_ready",  64'(in_ready),  64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mulrst_no_result", 64'(seen), 64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
